// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: opcodes, FSM states, default latencies.
// The GPR-writing mul path is enabled by defining MDU_MUL_GPR_EN.
package mdu_ctrl_pkg;

    localparam int unsigned MDU_OP_W            = 4;
    localparam int unsigned MDU_XLEN            = 32;
    localparam int unsigned MDU_RF_AW           = 5;
    localparam int unsigned MDU_MULT_CYCLES_DEF = 5;
    localparam int unsigned MDU_DIV_CYCLES_DEF  = 10;
    localparam int unsigned MDU_CNT_W_DEF       = 4;

    typedef enum logic [MDU_OP_W-1:0] {
        MDU_NONE = 4'd0,
        MULT     = 4'd1,
        MULTU    = 4'd2,
        DIV      = 4'd3,
        DIVU     = 4'd4,
        MTHI     = 4'd5,
        MTLO     = 4'd6,
        MADD     = 4'd7,
        MADDU    = 4'd8,
        MSUB     = 4'd9,
        MSUBU    = 4'd10,
        MUL      = 4'd11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    typedef struct packed {
        logic [MDU_XLEN-1:0] hi;
        logic [MDU_XLEN-1:0] lo;
    } mdu_hilo_t;

    function automatic logic mdu_is_div(input mdu_op_e op);
        return (op == DIV) || (op == DIVU);
    endfunction

    // Multi-cycle ops whose result lands in HI/LO.
    function automatic logic mdu_is_hilo_multi(input mdu_op_e op);
        return (op == MULT) || (op == MULTU) || (op == DIV)   || (op == DIVU) ||
               (op == MADD) || (op == MADDU) || (op == MSUB)  || (op == MSUBU);
    endfunction

endpackage

// File: rtl/mdu_ctrl_arith.sv
// Combinational datapath of the multiply/divide unit: the 64-bit {hi,lo} result of an op
// given its operands and the current HI/LO, plus whether HI/LO should take it.
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  mdu_op_e             i_op,
    input  logic [MDU_XLEN-1:0] i_a,
    input  logic [MDU_XLEN-1:0] i_b,
    input  logic [MDU_XLEN-1:0] i_hi,
    input  logic [MDU_XLEN-1:0] i_lo,
    output mdu_hilo_t           o_res,
    output logic                o_wr_hilo
);

    logic [2*MDU_XLEN-1:0] w_acc;
    logic [2*MDU_XLEN-1:0] w_prod_s;
    logic [2*MDU_XLEN-1:0] w_prod_u;
    logic                  w_sdiv;
    logic                  w_neg_a;
    logic                  w_neg_b;
    logic                  w_b_zero;
    logic [MDU_XLEN-1:0]   w_dvd;
    logic [MDU_XLEN-1:0]   w_dvs;
    logic [MDU_XLEN-1:0]   w_quo_m;
    logic [MDU_XLEN-1:0]   w_rem_m;
    logic [MDU_XLEN-1:0]   w_quo;
    logic [MDU_XLEN-1:0]   w_rem;

    assign w_acc    = {i_hi, i_lo};
    assign w_prod_s = {{MDU_XLEN{i_a[MDU_XLEN-1]}}, i_a} * {{MDU_XLEN{i_b[MDU_XLEN-1]}}, i_b};
    assign w_prod_u = {{MDU_XLEN{1'b0}}, i_a} * {{MDU_XLEN{1'b0}}, i_b};

    // One unsigned divider on magnitudes serves both div and divu; signs are restored after.
    assign w_sdiv   = (i_op == DIV);
    assign w_neg_a  = w_sdiv & i_a[MDU_XLEN-1];
    assign w_neg_b  = w_sdiv & i_b[MDU_XLEN-1];
    assign w_b_zero = (i_b == '0);
    assign w_dvd    = w_neg_a ? (~i_a + MDU_XLEN'(1)) : i_a;
    assign w_dvs    = w_b_zero ? MDU_XLEN'(1) : (w_neg_b ? (~i_b + MDU_XLEN'(1)) : i_b);
    assign w_quo_m  = w_dvd / w_dvs;
    assign w_rem_m  = w_dvd % w_dvs;
    assign w_quo    = (w_neg_a ^ w_neg_b) ? (~w_quo_m + MDU_XLEN'(1)) : w_quo_m;
    assign w_rem    = w_neg_a ? (~w_rem_m + MDU_XLEN'(1)) : w_rem_m;

    always_comb begin
        o_res     = w_acc;
        o_wr_hilo = 1'b0;
        case (i_op)
            MULT:  begin o_res = w_prod_s;         o_wr_hilo = 1'b1; end
            MULTU: begin o_res = w_prod_u;         o_wr_hilo = 1'b1; end
            MADD:  begin o_res = w_acc + w_prod_s; o_wr_hilo = 1'b1; end
            MADDU: begin o_res = w_acc + w_prod_u; o_wr_hilo = 1'b1; end
            MSUB:  begin o_res = w_acc - w_prod_s; o_wr_hilo = 1'b1; end
            MSUBU: begin o_res = w_acc - w_prod_u; o_wr_hilo = 1'b1; end
            DIV, DIVU: begin
                o_res     = {w_rem, w_quo};
                o_wr_hilo = ~w_b_zero;
            end
            MUL:   o_res = w_prod_s;
            default: begin
                o_res     = w_acc;
                o_wr_hilo = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller in E stage: sequences multi-cycle ops, owns HI/LO and
// drives the busy/ready/to_busy hazard handshake. MDU_MUL_GPR_EN enables the GPR-writing mul.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF,
    parameter int unsigned CNT_W       = MDU_CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [MDU_OP_W-1:0]  op,
    input  logic [MDU_XLEN-1:0]  a,
    input  logic [MDU_XLEN-1:0]  b,
    input  logic [MDU_RF_AW-1:0] dst,
    input  logic                 cancel,
    input  logic                 wb_ack,
    output logic                 to_busy,
    output logic                 busy,
    output logic                 ready,
    output logic [MDU_XLEN-1:0]  hi,
    output logic [MDU_XLEN-1:0]  lo,
    output logic                 rf_wr_pend,
    output logic [MDU_RF_AW-1:0] rf_dst,
    output logic                 rf_wr,
    output logic [MDU_XLEN-1:0]  rf_data
);

    localparam logic [CNT_W-1:0] MULT_LAT_M1 = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAT_M1  = CNT_W'(DIV_CYCLES - 1);

    mdu_state_e          r_state;
    logic [CNT_W-1:0]    r_cnt;
    mdu_op_e             r_op;
    logic [MDU_XLEN-1:0] r_a;
    logic [MDU_XLEN-1:0] r_b;
    logic [MDU_XLEN-1:0] r_hi;
    logic [MDU_XLEN-1:0] r_lo;
    logic                r_busy;
    logic                r_ready;

    mdu_op_e             w_op;
    logic                w_is_mul;
    logic                w_multi;
    logic                w_acc;
    logic [CNT_W-1:0]    w_lat_m1;
    mdu_hilo_t           w_res;
    logic                w_wr_hilo;

    assign w_op = mdu_op_e'(op);

`ifdef MDU_MUL_GPR_EN
    logic                 r_rf_wr_pend;
    logic [MDU_RF_AW-1:0] r_rf_dst;
    logic                 r_rf_wr;
    logic [MDU_XLEN-1:0]  r_rf_data;

    assign w_is_mul   = (w_op == MUL);
    assign rf_wr_pend = r_rf_wr_pend;
    assign rf_dst     = r_rf_dst;
    assign rf_wr      = r_rf_wr;
    assign rf_data    = r_rf_data;
`else
    logic w_unused;

    assign w_is_mul   = 1'b0;
    assign w_unused   = ^{dst, wb_ack};
    assign rf_wr_pend = 1'b0;
    assign rf_dst     = '0;
    assign rf_wr      = 1'b0;
    assign rf_data    = '0;
`endif

    assign w_multi  = mdu_is_hilo_multi(w_op) | w_is_mul;
    assign w_acc    = start & ~cancel & (r_state == ST_IDLE);
    assign to_busy  = w_acc & w_multi;
    assign w_lat_m1 = mdu_is_div(w_op) ? DIV_LAT_M1 : MULT_LAT_M1;

    assign busy  = r_busy;
    assign ready = r_ready;
    assign hi    = r_hi;
    assign lo    = r_lo;

    mdu_arith u_arith (
        .i_op      (r_op),
        .i_a       (r_a),
        .i_b       (r_b),
        .i_hi      (r_hi),
        .i_lo      (r_lo),
        .o_res     (w_res),
        .o_wr_hilo (w_wr_hilo)
    );

    // Control FSM; busy/ready are computed one edge ahead so they are plain flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= MDU_NONE;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
`ifdef MDU_MUL_GPR_EN
            r_rf_wr_pend <= 1'b0;
            r_rf_dst     <= '0;
            r_rf_wr      <= 1'b0;
            r_rf_data    <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_acc && (w_op == MTHI)) r_hi <= a;
                    if (w_acc && (w_op == MTLO)) r_lo <= a;
                    if (to_busy) begin
                        r_state <= ST_RUN;
                        r_cnt   <= w_lat_m1;
                        r_op    <= w_op;
                        r_a     <= a;
                        r_b     <= b;
                        r_busy  <= 1'b1;
`ifdef MDU_MUL_GPR_EN
                        r_rf_wr_pend <= w_is_mul;
                        r_rf_dst     <= w_is_mul ? dst : '0;
`endif
                    end
                end
                ST_RUN: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b0;
                        if (w_wr_hilo) begin
                            r_hi <= w_res.hi;
                            r_lo <= w_res.lo;
                        end
`ifdef MDU_MUL_GPR_EN
                        if (r_op == MUL) begin
                            r_state   <= ST_DONE;
                            r_busy    <= 1'b1;
                            r_ready   <= 1'b1;
                            r_rf_wr   <= 1'b1;
                            r_rf_data <= w_res.lo;
                        end
`endif
                    end else begin
                        r_cnt   <= r_cnt - CNT_W'(1);
                        r_ready <= (r_cnt == CNT_W'(1));
                    end
                end
`ifdef MDU_MUL_GPR_EN
                ST_DONE: begin
                    if (wb_ack) begin
                        r_state      <= ST_IDLE;
                        r_busy       <= 1'b0;
                        r_ready      <= 1'b0;
                        r_rf_wr_pend <= 1'b0;
                        r_rf_dst     <= '0;
                        r_rf_wr      <= 1'b0;
                        r_rf_data    <= '0;
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: directed cases plus random ops checked against an
// arithmetic reference model; honours MDU_MUL_GPR_EN for the mul path.
`timescale 1ns/1ps
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dst;
    logic        cancel;
    logic        wb_ack;
    logic        to_busy;
    logic        busy;
    logic        ready;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        rf_wr_pend;
    logic [4:0]  rf_dst;
    logic        rf_wr;
    logic [31:0] rf_data;

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .dst(dst),
        .cancel(cancel), .wb_ack(wb_ack), .to_busy(to_busy), .busy(busy), .ready(ready),
        .hi(hi), .lo(lo), .rf_wr_pend(rf_wr_pend), .rf_dst(rf_dst), .rf_wr(rf_wr),
        .rf_data(rf_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_gpr;
        logic [63:0] hilo;
        logic [31:0] data;
        logic [4:0]  rd;
    } exp_t;

    exp_t        sb_q[$];
    logic [63:0] m_hilo;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic is_gpr_op(input logic [3:0] o);
`ifdef MDU_MUL_GPR_EN
        return o == MUL;
`else
        return o == 4'hF && 1'b0;
`endif
    endfunction

    function automatic logic is_multi(input logic [3:0] o);
        return (o == MULT) || (o == MULTU) || (o == DIV) || (o == DIVU) || (o == MADD) ||
               (o == MADDU) || (o == MSUB) || (o == MSUBU) || is_gpr_op(o);
    endfunction

    // Reference arithmetic written from the ISA rules with 64-bit/int math.
    function automatic exp_t ref_model(input logic [3:0] o, input logic [31:0] x,
                                       input logic [31:0] y, input logic [63:0] acc);
        exp_t        e;
        longint      sx;
        longint      sy;
        logic [63:0] ps;
        logic [63:0] pu;
        int          ix;
        int          iy;
        int          q;
        int          r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ps = 64'(sx * sy);
        pu = {32'd0, x} * {32'd0, y};
        e.is_gpr = 1'b0;
        e.hilo   = acc;
        e.data   = 32'd0;
        e.rd     = 5'd0;
        case (o)
            MULT:  e.hilo = ps;
            MULTU: e.hilo = pu;
            MADD:  e.hilo = acc + ps;
            MADDU: e.hilo = acc + pu;
            MSUB:  e.hilo = acc - ps;
            MSUBU: e.hilo = acc - pu;
            MTHI:  e.hilo = {x, acc[31:0]};
            MTLO:  e.hilo = {acc[63:32], x};
            DIVU:  if (y != 0) e.hilo = {x % y, x / y};
            DIV: begin
                if (y == 0) begin
                    e.hilo = acc;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    e.hilo = {32'd0, 32'h8000_0000};
                end else begin
                    ix = $signed(x);
                    iy = $signed(y);
                    q  = ix / iy;
                    r  = ix % iy;
                    e.hilo = {32'(r), 32'(q)};
                end
            end
            default: e.hilo = acc;
        endcase
        if (is_gpr_op(o)) begin
            e.is_gpr = 1'b1;
            e.hilo   = acc;
            e.data   = ps[31:0];
        end
        return e;
    endfunction

    // Monitor: HI/LO land one edge after ready (non-GPR ops); GPR write pops on wb_ack.
    logic hilo_due = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (hilo_due) begin
            if (sb_q.size() == 0) begin
                total++; bad++;
                $display("FAIL sb_underflow: hilo update with empty scoreboard (t=%0t)", $time);
            end else begin
                e = sb_q.pop_front();
                chk("sb_is_gpr", 64'(1'b0), 64'(e.is_gpr));
                chk("sb_hilo", {hi, lo}, e.hilo);
            end
        end
        hilo_due = (ready === 1'b1) && (rf_wr_pend !== 1'b1) && (reset !== 1'b1);
        if (rf_wr === 1'b1 && wb_ack === 1'b1) begin
            if (sb_q.size() == 0) begin
                total++; bad++;
                $display("FAIL sb_underflow: rf write with empty scoreboard (t=%0t)", $time);
            end else begin
                e = sb_q.pop_front();
                chk("sb_rf_data", 64'(rf_data), 64'(e.data));
                chk("sb_rf_dst", 64'(rf_dst), 64'(e.rd));
                chk("sb_rf_hilo", {hi, lo}, e.hilo);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; start = 1'b0; cancel = 1'b0; wb_ack = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        sb_q.delete();
        m_hilo = 64'd0;
    endtask

    // Issue one instruction in E; intrude pulses an extra start while the unit is busy.
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] rd, input logic can, input logic intrude);
        logic multi;
        logic gpr;
        exp_t e;
        int   lat;
        int   n;
        int   rdy_at;
        multi = is_multi(o);
        gpr   = is_gpr_op(o);
        lat   = (o == DIV || o == DIVU) ? DC : MC;
        @(posedge clk); #1;
        start = 1'b1; op = o; a = x; b = y; dst = rd; cancel = can;
        #1;
        chk("to_busy", 64'(to_busy), 64'(multi && !can));
        if (!can) begin
            e = ref_model(o, x, y, m_hilo);
            e.rd = rd;
            m_hilo = e.hilo;
            if (multi) sb_q.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0; op = 4'd0;
        if (!(multi && !can)) begin
            @(negedge clk);
            chk("single_busy", 64'(busy), 64'(1'b0));
            chk("single_hilo", {hi, lo}, m_hilo);
            return;
        end
        n = 0;
        rdy_at = -1;
        @(negedge clk);
        while (busy === 1'b1 && rf_wr !== 1'b1 && n < 60) begin
            n++;
            if (ready === 1'b1 && rdy_at < 0) rdy_at = n;
            if (gpr) begin
                chk("run_rf_pend", 64'(rf_wr_pend), 64'(1'b1));
                chk("run_rf_dst", 64'(rf_dst), 64'(rd));
            end
            if (intrude && n == 2) begin
                start = 1'b1; op = MULT; a = $urandom(); b = $urandom();
                #1;
                chk("busy_start_to_busy", 64'(to_busy), 64'(1'b0));
            end
            if (intrude && n == 3) start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        chk("run_len", 64'(n), 64'(lat));
        chk("ready_cycle", 64'(rdy_at), 64'(lat));
        if (gpr) begin
            for (int k = 0; k < 3; k++) begin
                if (k > 0) @(negedge clk);
                chk("done_rf_wr", 64'(rf_wr), 64'(1'b1));
                chk("done_busy_ready", 64'({busy, ready}), 64'(2'b11));
                chk("done_rf_data", 64'(rf_data), 64'(e.data));
                chk("done_rf_dst", 64'(rf_dst), 64'(rd));
            end
            @(posedge clk); #1;
            wb_ack = 1'b1; start = 1'b1; op = MULT; a = 32'd3; b = 32'd3;
            #1;
            chk("done_start_to_busy", 64'(to_busy), 64'(1'b0));
            @(posedge clk); #1;
            wb_ack = 1'b0; start = 1'b0; op = 4'd0;
            @(negedge clk);
            chk("after_wb_state", 64'({busy, rf_wr, rf_wr_pend}), 64'(3'b000));
        end
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0; dst = 5'd0;
        cancel = 1'b0; wb_ack = 1'b0;
        m_hilo = 64'd0;
        do_reset();
        @(negedge clk);
        chk("reset_ctl", 64'({to_busy, busy, ready, rf_wr_pend, rf_wr}), 64'(5'b0));
        chk("reset_hilo", {hi, lo}, 64'd0);
        chk("reset_rf", 64'({rf_dst, rf_data}), 64'd0);

        issue(MULT, 32'hFFFF_FFFF, 32'd2, 5'd0, 1'b0, 1'b0);
        chk("mult_plan", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        issue(DIVU, 32'd100, 32'd7, 5'd0, 1'b0, 1'b0);
        chk("divu_plan", {hi, lo}, {32'd2, 32'd14});
        issue(DIV, 32'hFFFF_FFF9, 32'd2, 5'd0, 1'b0, 1'b0);
        chk("div_neg_plan", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 1'b0, 1'b0);
        chk("div_ovf_plan", {hi, lo}, {32'd0, 32'h8000_0000});
        issue(DIV, 32'd1234, 32'd0, 5'd0, 1'b0, 1'b0);
        chk("div_zero_plan", {hi, lo}, {32'd0, 32'h8000_0000});
        issue(MTHI, 32'h1234_5678, 32'd0, 5'd0, 1'b0, 1'b0);
        issue(MTLO, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        issue(MADD, 32'd3, 32'd4, 5'd0, 1'b0, 1'b0);
        chk("madd_plan", {hi, lo}, {32'h1234_5678, 32'd12});
        issue(DIV, 32'd50, 32'd5, 5'd0, 1'b1, 1'b0);
        chk("cancel_plan", {hi, lo}, {32'h1234_5678, 32'd12});
        issue(DIVU, 32'd1000, 32'd33, 5'd0, 1'b0, 1'b1);
        issue(MUL, 32'd6, 32'd7, 5'd9, 1'b0, 1'b0);

        // Reset in the second RUN cycle of a mult aborts it and clears HI/LO.
        @(posedge clk); #1;
        start = 1'b1; op = MULT; a = 32'd5; b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0; op = 4'd0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb_q.delete();
        m_hilo = 64'd0;
        @(negedge clk);
        chk("reset_mid_busy", 64'(busy), 64'(1'b0));
        chk("reset_mid_hilo", {hi, lo}, 64'd0);

        for (int i = 0; i < 80; i++) begin
            logic [3:0]  ro;
            logic [31:0] rx;
            logic [31:0] ry;
            ro = 4'($urandom_range(0, 11));
            rx = rand_opnd();
            ry = rand_opnd();
            issue(ro, rx, ry, 5'($urandom_range(1, 31)), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 9) == 0));
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        chk("final_hilo", {hi, lo}, m_hilo);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
        $fatal(1, "watchdog");
    end

endmodule
